// File: rtl/i2c_cmd_scheduler.sv
// rtl/i2c_cmd_scheduler.sv - picks the next i2cmaster command: queued PC instruction or periodic temperature poll
// One command in flight at a time; a watchdog aborts transactions whose completion never arrives.
module i2c_cmd_scheduler #(
  parameter int unsigned POLL_CYCLES    = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned MAX_PC_BURST   = 4,
  parameter logic [7:0]  DEF_MODE       = 8'h02,
  parameter logic [7:0]  DEF_ADDR       = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_valid,
  input  logic [7:0]  pc_mode,
  input  logic [7:0]  pc_addr,
  input  logic [15:0] pc_data,
  output logic        pc_pop,
  input  logic        master_free,
  input  logic        i2c_done,
  input  logic        full_resbuf,
  output logic        i2c_start,
  output logic [7:0]  i2c_mode,
  output logic [7:0]  i2c_address,
  output logic [15:0] i2c_data,
  output logic [1:0]  i2c_tag,
  output logic        i2c_abort,
  output logic        timeout_err,
  output logic        poll_overrun
);
  localparam int PW = $clog2(POLL_CYCLES);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam int BW = $clog2(MAX_PC_BURST + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_PC_BURST);
  localparam logic [1:0]    TAG_DEF   = 2'b01;
  localparam logic [1:0]    TAG_PC    = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_t;

  state_t        state;
  logic [PW-1:0] poll_cnt;
  logic          poll_due;
  logic [BW-1:0] burst_cnt;
  logic [WW-1:0] watchdog;
  logic [7:0]    cmd_mode;
  logic [7:0]    cmd_addr;
  logic [15:0]   cmd_data;
  logic [1:0]    cmd_tag;

  logic poll_wrap;
  logic can_grant;
  logic take_def;
  logic take_pc;

  assign poll_wrap = (poll_cnt == POLL_LAST);
  assign can_grant = (state == S_IDLE) && master_free && !full_resbuf;
  // PC normally wins; the poll only forces its way in once the PC burst allowance is used up
  assign take_def  = can_grant && poll_due && (!pc_valid || burst_cnt == BURST_MAX);
  assign take_pc   = can_grant && pc_valid && !take_def;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      poll_cnt     <= '0;
      poll_due     <= 1'b0;
      burst_cnt    <= '0;
      watchdog     <= '0;
      cmd_mode     <= '0;
      cmd_addr     <= '0;
      cmd_data     <= '0;
      cmd_tag      <= '0;
      pc_pop       <= 1'b0;
      i2c_start    <= 1'b0;
      i2c_mode     <= '0;
      i2c_address  <= '0;
      i2c_data     <= '0;
      i2c_tag      <= '0;
      i2c_abort    <= 1'b0;
      timeout_err  <= 1'b0;
      poll_overrun <= 1'b0;
    end else begin
      pc_pop       <= 1'b0;
      i2c_start    <= 1'b0;
      i2c_abort    <= 1'b0;
      timeout_err  <= 1'b0;
      poll_overrun <= 1'b0;

      poll_cnt <= poll_wrap ? '0 : poll_cnt + 1'b1;
      // a wrap landing on the default grant opens a fresh interval instead of overrunning
      if (poll_wrap) begin
        poll_due <= 1'b1;
        if (poll_due && !take_def) poll_overrun <= 1'b1;
      end else if (take_def) begin
        poll_due <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (take_def) begin
            cmd_mode  <= DEF_MODE;
            cmd_addr  <= DEF_ADDR;
            cmd_data  <= 16'h0000;
            cmd_tag   <= TAG_DEF;
            burst_cnt <= '0;
            state     <= S_ISSUE;
          end else if (take_pc) begin
            cmd_mode  <= pc_mode;
            cmd_addr  <= pc_addr;
            cmd_data  <= pc_data;
            cmd_tag   <= TAG_PC;
            pc_pop    <= 1'b1;
            burst_cnt <= poll_due ? burst_cnt + 1'b1 : '0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          i2c_start   <= 1'b1;
          i2c_mode    <= cmd_mode;
          i2c_address <= cmd_addr;
          i2c_data    <= cmd_data;
          i2c_tag     <= cmd_tag;
          watchdog    <= '0;
          state       <= S_BUSY;
        end
        S_BUSY: begin
          if (i2c_done) begin
            state <= S_IDLE;
          end else if (watchdog == WD_LAST) begin
            i2c_abort   <= 1'b1;
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_scheduler.sv
// tb/tb_i2c_cmd_scheduler.sv - directed vectors, corner sequences and random run against a cycle-stamp model
module tb_i2c_cmd_scheduler;
  localparam int P = 50;
  localparam int T = 20;
  localparam int B = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_valid = 1'b0;
  logic [7:0]  pc_mode = '0;
  logic [7:0]  pc_addr = '0;
  logic [15:0] pc_data = '0;
  logic        master_free = 1'b0;
  logic        i2c_done = 1'b0;
  logic        full_resbuf = 1'b0;
  logic        pc_pop, i2c_start, i2c_abort, timeout_err, poll_overrun;
  logic [7:0]  i2c_mode, i2c_address;
  logic [15:0] i2c_data;
  logic [1:0]  i2c_tag;

  int checks = 0;
  int errors = 0;
  int ecount = 0;

  i2c_cmd_scheduler #(.POLL_CYCLES(P), .TIMEOUT_CYCLES(T), .MAX_PC_BURST(B),
                      .DEF_MODE(8'h02), .DEF_ADDR(8'h00)) dut (
    .clk(clk), .reset(rst),
    .pc_valid(pc_valid), .pc_mode(pc_mode), .pc_addr(pc_addr), .pc_data(pc_data), .pc_pop(pc_pop),
    .master_free(master_free), .i2c_done(i2c_done), .full_resbuf(full_resbuf),
    .i2c_start(i2c_start), .i2c_mode(i2c_mode), .i2c_address(i2c_address), .i2c_data(i2c_data),
    .i2c_tag(i2c_tag), .i2c_abort(i2c_abort), .timeout_err(timeout_err), .poll_overrun(poll_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ecount++;
  endtask

  // Reference model: edge index since reset drives poll timing, busy age drives the timeout.
  int          m_cyc, m_burst, m_phase, m_since;
  bit          m_due;
  logic [33:0] m_pend, m_out;
  bit          e_pop, e_start, e_abort, e_over;

  task automatic model_reset();
    m_cyc = 0; m_burst = 0; m_phase = 0; m_since = 0; m_due = 0;
    m_pend = '0; m_out = '0;
  endtask

  task automatic model_step();
    bit wrap, took_def;
    e_pop = 0; e_start = 0; e_abort = 0; e_over = 0; took_def = 0;
    wrap = ((m_cyc % P) == P - 1);
    if (m_phase == 0) begin
      if (master_free && !full_resbuf) begin
        if (m_due && (!pc_valid || m_burst == B)) begin
          m_pend = {8'h02, 8'h00, 16'h0000, 2'b01};
          took_def = 1; m_burst = 0; m_phase = 1;
        end else if (pc_valid) begin
          m_pend = {pc_mode, pc_addr, pc_data, 2'b10};
          e_pop = 1; m_burst = m_due ? m_burst + 1 : 0; m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      e_start = 1; m_out = m_pend; m_since = m_cyc; m_phase = 2;
    end else begin
      if (i2c_done) m_phase = 0;
      else if (m_cyc - m_since == T) begin e_abort = 1; m_phase = 0; end
    end
    if (wrap) begin
      if (m_due && !took_def) e_over = 1;
      m_due = 1;
    end else if (took_def) begin
      m_due = 0;
    end
    m_cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; pc_valid = 0; master_free = 0; i2c_done = 0; full_resbuf = 0;
    @(posedge clk);
    #1;
    chk("reset_outputs", 64'({pc_pop, i2c_start, i2c_mode, i2c_address, i2c_data, i2c_tag,
                              i2c_abort, timeout_err, poll_overrun}), 64'(0));
    rst = 1'b0;
    ecount = 0;
    model_reset();
  endtask

  typedef struct packed {
    logic       pv;
    logic [7:0] mode;
    logic       mf;
    logic       full;
    logic       done;
    logic       e_pop;
    logic       e_start;
    logic [1:0] e_tag;
    logic [7:0] e_mode;
  } vec_t;

  vec_t       tbl [10];
  logic [1:0] burst_exp [7] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10};

  initial begin
    int n;
    int found;
    logic [1:0] got [8];

    tbl[0] = '{1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00};
    tbl[1] = '{1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 8'h04};
    tbl[2] = '{1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 8'h04};
    tbl[3] = '{1'b0, 8'h04, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 8'h04};
    tbl[4] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 8'h04};
    tbl[5] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 8'h04};
    tbl[6] = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 8'h04};
    tbl[7] = '{1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 8'h55};
    tbl[8] = '{1'b0, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 8'h55};
    tbl[9] = '{1'b0, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 8'h55};

    // PC issue, full_resbuf/master_free hold-off and stale done
    do_reset();
    pc_addr = 8'h03; pc_data = 16'h1234;
    for (int i = 0; i < 10; i++) begin
      pc_valid = tbl[i].pv; pc_mode = tbl[i].mode; master_free = tbl[i].mf;
      full_resbuf = tbl[i].full; i2c_done = tbl[i].done;
      step();
      chk($sformatf("vec%0d", i), 64'({pc_pop, i2c_start, i2c_tag, i2c_mode}),
          64'({tbl[i].e_pop, tbl[i].e_start, tbl[i].e_tag, tbl[i].e_mode}));
    end
    chk("held_addr_data", 64'({i2c_address, i2c_data}), 64'({8'h03, 16'h1234}));

    // default poll alone: starts on edges 51 and 101
    do_reset();
    master_free = 1;
    found = -1;
    for (int c = 0; c < 200; c++) begin
      step();
      if (i2c_start) begin found = ecount - 1; break; end
    end
    chk("first_poll_edge", 64'(found), 64'(51));
    chk("first_poll_cmd", 64'({i2c_mode, i2c_address, i2c_data, i2c_tag}), 64'({8'h02, 8'h00, 16'h0, 2'b01}));
    step();
    i2c_done = 1; step(); i2c_done = 0;
    found = -1;
    for (int c = 0; c < 200; c++) begin
      step();
      if (i2c_start) begin found = ecount - 1; break; end
    end
    chk("second_poll_edge", 64'(found), 64'(101));

    // watchdog abort 20 cycles after BUSY entry
    do_reset();
    master_free = 1; pc_valid = 1; pc_mode = 8'h11;
    step();
    chk("to_pop", 64'(pc_pop), 64'(1));
    pc_valid = 0;
    step();
    chk("to_start", 64'(i2c_start), 64'(1));
    n = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (i2c_abort) begin n = c; break; end
    end
    chk("abort_delay", 64'(n), 64'(T));
    chk("timeout_err_with_abort", 64'(timeout_err), 64'(1));
    step();
    chk("abort_is_pulse", 64'({i2c_abort, timeout_err}), 64'(0));
    pc_valid = 1;
    step();
    chk("idle_after_abort", 64'(pc_pop), 64'(1));

    // burst cap: 4 PC issues, one default, PC resumes
    do_reset();
    repeat (53) step();
    pc_valid = 1; pc_mode = 8'h21; pc_addr = 8'h07; pc_data = 16'hBEEF; master_free = 1;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      i2c_done = 0;
      if (i2c_start) begin
        if (n < 8) got[n] = i2c_tag;
        n++;
        i2c_done = 1;
      end
    end
    i2c_done = 0;
    chk("burst_issue_count", 64'(n >= 7), 64'(1));
    for (int i = 0; i < 7; i++)
      chk($sformatf("burst_tag%0d", i), 64'(got[i]), 64'(burst_exp[i]));

    // full_resbuf blocks everything, release issues PC within 2 cycles
    do_reset();
    repeat (55) step();
    pc_valid = 1; full_resbuf = 1; master_free = 1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (i2c_start || pc_pop) n++;
    end
    chk("full_blocks", 64'(n), 64'(0));
    full_resbuf = 0;
    step();
    chk("full_release_pop", 64'(pc_pop), 64'(1));
    pc_valid = 0;
    step();
    chk("full_release_start", 64'({i2c_start, i2c_tag}), 64'({1'b1, 2'b10}));

    // two wraps while master busy: one overrun, one default read
    do_reset();
    n = 0;
    for (int c = 0; c < 120; c++) begin
      step();
      if (poll_overrun) n++;
    end
    chk("overrun_count", 64'(n), 64'(1));
    master_free = 1;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      i2c_done = 0;
      if (i2c_start) begin
        n++;
        chk("overrun_tag", 64'(i2c_tag), 64'(2'b01));
        i2c_done = 1;
      end
    end
    i2c_done = 0;
    chk("single_default", 64'(n), 64'(1));

    // random run against the model, with a reset in the middle
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      pc_valid    = ($urandom_range(0, 3) != 0);
      pc_mode     = 8'($urandom);
      pc_addr     = 8'($urandom);
      pc_data     = 16'($urandom);
      master_free = ($urandom_range(0, 7) != 0);
      full_resbuf = ($urandom_range(0, 9) == 0);
      i2c_done    = ($urandom_range(0, 15) == 0);
      model_step();
      step();
      chk($sformatf("rand%0d", i),
          64'({pc_pop, i2c_start, i2c_abort, timeout_err, poll_overrun,
               i2c_mode, i2c_address, i2c_data, i2c_tag}),
          64'({e_pop, e_start, e_abort, e_abort, e_over, m_out}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
